// File: rtl/polvecp_to_bs.sv
// Packs 10-bit mod-p polynomial coefficients from the four-lane unpacked memory layout
// into the contiguous little-endian 10-bit bitstream, 8 reads -> 5 writes per group.
module polvecp_to_bs #(
    parameter int unsigned NUM_GROUPS = 24,
    parameter int unsigned ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [63:0]       read_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [63:0]       write_data,
    output logic              write_en,
    output logic              done
);

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned PACK_W   = 40;
    localparam int unsigned BUF_W    = 320;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned RD_WORDS = 8;
    localparam int unsigned WR_WORDS = 5;
    localparam int unsigned GRP_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [GRP_W-1:0]    grp_cnt_q, grp_cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;

    logic [PACK_W-1:0]   lane_pack;
    logic                lane_junk_unused;

    // Keep the low 10 bits of each 16-bit lane; the upper 6 bits carry no data.
    assign lane_pack = {read_data[57:48], read_data[41:32], read_data[25:16], read_data[9:0]};
    assign lane_junk_unused = ^{read_data[63:58], read_data[47:42],
                                read_data[31:26], read_data[15:10]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            grp_cnt_q <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            buf_q     <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            grp_cnt_q <= grp_cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            buf_q     <= buf_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        grp_cnt_d = grp_cnt_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        buf_d     = buf_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RD;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    grp_cnt_d = '0;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                end
            end

            // Read data lags the address by one cycle, so the first RD cycle loads nothing.
            S_RD: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (rd_cnt_q != '0) begin
                    buf_d = {lane_pack, buf_q[BUF_W-1:PACK_W]};
                end
                if (rd_cnt_q == CNT_W'(RD_WORDS - 1)) begin
                    rd_cnt_d = '0;
                    state_d  = S_CAP;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end

            S_CAP: begin
                buf_d   = {lane_pack, buf_q[BUF_W-1:PACK_W]};
                state_d = S_WR;
            end

            S_WR: begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                buf_d     = {{WORD_W{1'b0}}, buf_q[BUF_W-1:WORD_W]};
                if (wr_cnt_q == CNT_W'(WR_WORDS - 1)) begin
                    wr_cnt_d = '0;
                    if (grp_cnt_q == GRP_W'(NUM_GROUPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        grp_cnt_d = grp_cnt_q + GRP_W'(1);
                        state_d   = S_RD;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of the upcoming state, so they align with the state.
        rd_en_d = (state_d == S_RD);
        wr_en_d = (state_d == S_WR);
        done_d  = (state_d == S_DONE);
    end

    assign read_address  = rd_addr_q;
    assign read_en       = rd_en_q;
    assign write_address = wr_addr_q;
    assign write_data    = buf_q[WORD_W-1:0];
    assign write_en      = wr_en_q;
    assign done          = done_q;

endmodule

// File: tb/tb_polvecp_to_bs.sv
// Directed and model-based bench for polvecp_to_bs: vector table for the first group,
// plus full runs, mid-run reset, ignored start and restart from DONE.
module tb_polvecp_to_bs;

    localparam int unsigned NUM_GROUPS = 24;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned N_RD       = NUM_GROUPS * 8;
    localparam int unsigned N_WR       = NUM_GROUPS * 5;
    localparam int unsigned RUN_CYC    = NUM_GROUPS * 14;
    localparam int unsigned LOG_SZ     = 4096;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [63:0]       read_data;
    logic [ADDR_W-1:0] write_address;
    logic [63:0]       write_data;
    logic              write_en;
    logic              done;

    polvecp_to_bs #(.NUM_GROUPS(NUM_GROUPS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .read_address (read_address),
        .read_en      (read_en),
        .read_data    (read_data),
        .write_address(write_address),
        .write_data   (write_data),
        .write_en     (write_en),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:N_RD-1];

    // Unpacked memory with one-cycle read latency.
    always @(posedge clk) begin
        if (read_en) read_data <= mem[read_address];
    end

    int          wr_n = 0;
    int          rd_n = 0;
    int          overlap_n = 0;
    logic [63:0] wr_data_log [LOG_SZ];
    int          wr_addr_log [LOG_SZ];

    always @(negedge clk) begin
        if (write_en && wr_n < LOG_SZ) begin
            wr_data_log[wr_n] = write_data;
            wr_addr_log[wr_n] = int'(write_address);
            wr_n = wr_n + 1;
        end
        if (read_en) rd_n = rd_n + 1;
        if (read_en && write_en) overlap_n = overlap_n + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bitstream model: stream bit 10n+b is bit b of coefficient n.
    function automatic logic [63:0] exp_word(input int w);
        logic [63:0] r;
        logic [63:0] src;
        int sb, n, b;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            sb  = 64 * w + i;
            n   = sb / 10;
            b   = sb % 10;
            src = mem[n / 4];
            r[i] = src[16 * (n % 4) + b];
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < int'(N_RD); i++) mem[i] = {$urandom(), $urandom()};
    endtask

    task automatic check_run(input string tag, input int base);
        for (int w = 0; w < int'(N_WR); w++) begin
            check64($sformatf("%s data[%0d]", tag, w), wr_data_log[base + w], exp_word(w));
            check_int($sformatf("%s addr[%0d]", tag, w), wr_addr_log[base + w], w);
        end
    endtask

    // Pulses start, optionally re-pulses it at cycle glitch_at, and waits for done.
    task automatic run(input string tag, input int glitch_at, output int base);
        int cyc;
        int rd_base;
        base    = wr_n;
        rd_base = rd_n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 2 * int'(RUN_CYC)) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1 start = 1'b0;
            @(negedge clk);
            if (cyc == glitch_at) start = 1'b1;
            if (done) break;
        end
        check_int({tag, " done cycle"}, cyc, int'(RUN_CYC));
        check_int({tag, " reads"}, rd_n - rd_base, int'(N_RD));
        check_int({tag, " writes"}, wr_n - base, int'(N_WR));
    endtask

    typedef struct packed {
        logic [63:0]      fill;
        int               poke_coeff;
        logic [15:0]      poke_val;
        logic [4:0][63:0] exp_w;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] fill, input int pc, input logic [15:0] pv,
                                input logic [63:0] w0, input logic [63:0] w1,
                                input logic [63:0] w2, input logic [63:0] w3,
                                input logic [63:0] w4);
        vec_t v;
        v.fill       = fill;
        v.poke_coeff = pc;
        v.poke_val   = pv;
        v.exp_w[0]   = w0;
        v.exp_w[1]   = w1;
        v.exp_w[2]   = w2;
        v.exp_w[3]   = w3;
        v.exp_w[4]   = w4;
        return v;
    endfunction

    localparam int N_TV = 6;
    vec_t tv [N_TV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [63:0] w;
        logic [63:0] ones;

        ones = '1;
        tv[0] = mk(64'h03FF_03FF_03FF_03FF, -1, 16'h0000, ones, ones, ones, ones, ones);
        tv[1] = mk(64'h0, 6, 16'h03FF, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_003F,
                   64'h0, 64'h0, 64'h0);
        tv[2] = mk(64'hFC00_FC00_FC00_FC00, -1, 16'h0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        tv[3] = mk(64'h0, 31, 16'h03FF, 64'h0, 64'h0, 64'h0, 64'h0, 64'hFFC0_0000_0000_0000);
        tv[4] = mk(64'h0, 12, 16'h02A5, 64'h0, 64'hA500_0000_0000_0000,
                   64'h0000_0000_0000_0002, 64'h0, 64'h0);
        tv[5] = mk(64'h0, 0, 16'hFC01, 64'h0000_0000_0000_0001, 64'h0, 64'h0, 64'h0, 64'h0);

        rst   = 1'b0;
        start = 1'b0;
        read_data = '0;
        for (int i = 0; i < int'(N_RD); i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset read_address", int'(read_address), 0);
        check_int("reset write_address", int'(write_address), 0);
        check_int("reset strobes/done", int'({read_en, write_en, done}), 0);
        check64("reset write_data", write_data, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_int("idle strobes/done", int'({read_en, write_en, done}), 0);

        for (int t = 0; t < N_TV; t++) begin
            for (int i = 0; i < int'(N_RD); i++) mem[i] = tv[t].fill;
            if (tv[t].poke_coeff >= 0) begin
                w = mem[tv[t].poke_coeff / 4];
                w[16 * (tv[t].poke_coeff % 4) +: 16] = tv[t].poke_val;
                mem[tv[t].poke_coeff / 4] = w;
            end
            run($sformatf("vec%0d", t), -1, base);
            for (int k = 0; k < 5; k++) begin
                check64($sformatf("vec%0d write%0d", t, k), wr_data_log[base + k], tv[t].exp_w[k]);
                check_int($sformatf("vec%0d addr%0d", t, k), wr_addr_log[base + k], k);
            end
            check_int($sformatf("vec%0d final read_address", t), int'(read_address), int'(N_RD));
            check_int($sformatf("vec%0d final write_address", t), int'(write_address), int'(N_WR));
        end

        fill_random();
        run("random", -1, base);
        check_run("random", base);

        // Abort during the write phase of group 5, then a clean full run.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (81) @(posedge clk);
        #2;
        check_int("pre-reset write_en", int'(write_en), 1);
        rst = 1'b0;
        #1;
        check_int("abort read_address", int'(read_address), 0);
        check_int("abort write_address", int'(write_address), 0);
        check_int("abort strobes/done", int'({read_en, write_en, done}), 0);
        check64("abort write_data", write_data, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_int("post-abort idle", int'({read_en, write_en, done}), 0);
        run("after-abort", -1, base);
        check_run("after-abort", base);

        // start mid-RD must not disturb the run.
        fill_random();
        run("glitch", 3, base);
        check_run("glitch", base);
        repeat (3) @(negedge clk);
        check_int("done held", int'(done), 1);
        check_int("done read_address", int'(read_address), int'(N_RD));
        check_int("done write_address", int'(write_address), int'(N_WR));

        // Restart from DONE: counters and addresses return to 0.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_int("restart done", int'(done), 0);
        check_int("restart read_address", int'(read_address), 0);
        check_int("restart write_address", int'(write_address), 0);
        check_int("restart read_en", int'(read_en), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_int("restart read_address+1", int'(read_address), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run("restart", -1, base);
        check_run("restart", base);

        check_int("read/write strobe overlap", overlap_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
